// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_wait_timer.sv
// IM wait budget: loads MAX_WAIT-1 on clear, counts down while enabled,
// and flags expiry once the last allowed wait cycle is reached.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LOAD = 8'(MAX_WAIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && count != '0) begin
      count <= count - 8'd1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the PC, runs the IM read handshake and
// writes fetched instructions into the IR.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        npc_wr,
  input  logic [31:0] npc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        irwr,
  output logic [31:0] ir_data,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  state_t      state, state_d;
  logic [31:0] pc_d, im_addr_d, ir_data_d, pend_pc, pend_pc_d;
  logic        im_req_d, irwr_d, fault_d, pend_valid, pend_valid_d;
  logic [1:0]  fault_code_d;
  logic        misaligned, start, tmr_clear, tmr_en, tmr_expire;

  assign misaligned = (pc[1:0] != 2'b00);
  assign start      = (state == IDLE) && fetch_en && !npc_wr && !misaligned;
  assign tmr_clear  = start;
  assign tmr_en     = (state == REQ) && !im_ack;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      im_req     <= 1'b0;
      im_addr    <= '0;
      irwr       <= 1'b0;
      ir_data    <= '0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      im_req     <= im_req_d;
      im_addr    <= im_addr_d;
      irwr       <= irwr_d;
      ir_data    <= ir_data_d;
      busy       <= (state_d != IDLE);
      fault      <= fault_d;
      fault_code <= fault_code_d;
      pend_valid <= pend_valid_d;
      pend_pc    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (!npc_wr && fetch_en) state_d = misaligned ? FAULT : REQ;
      end
      REQ: begin
        if (im_ack)          state_d = DONE;
        else if (tmr_expire) state_d = FAULT;
      end
      DONE:  state_d = IDLE;
      FAULT: if (npc_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc;
    im_req_d     = im_req;
    im_addr_d    = im_addr;
    irwr_d       = 1'b0;
    ir_data_d    = ir_data;
    fault_d      = fault;
    fault_code_d = fault_code;
    pend_valid_d = pend_valid;
    pend_pc_d    = pend_pc;
    unique case (state)
      IDLE: begin
        if (npc_wr) begin
          pc_d = npc;
        end else if (fetch_en) begin
          if (misaligned) begin
            fault_d      = 1'b1;
            fault_code_d = FC_MISALIGN;
          end else begin
            im_req_d     = 1'b1;
            im_addr_d    = pc;
            pend_valid_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (npc_wr) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = npc;
        end
        if (im_ack) begin
          // A redirect written on the ack cycle itself is the latest one.
          ir_data_d    = im_rdata;
          irwr_d       = 1'b1;
          im_req_d     = 1'b0;
          pend_valid_d = 1'b0;
          if (npc_wr)          pc_d = npc;
          else if (pend_valid) pc_d = pend_pc;
          else                 pc_d = pc + 32'd4;
        end else if (tmr_expire) begin
          im_req_d     = 1'b0;
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
          pend_valid_d = 1'b0;
        end
      end
      DONE: begin
        if (npc_wr) pc_d = npc;
      end
      FAULT: begin
        if (npc_wr) begin
          pc_d         = npc;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, fetch_en, npc_wr, im_ack;
  logic [31:0] npc, im_rdata;
  logic        im_req, irwr, busy, fault;
  logic [31:0] im_addr, ir_data, pc;
  logic [1:0]  fault_code;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_seq #(.RESET_PC(32'h0000_3000), .MAX_WAIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .npc_wr     (npc_wr),
    .npc        (npc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .irwr       (irwr),
    .ir_data    (ir_data),
    .pc         (pc),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; npc_wr = 1'b0; npc = '0; im_ack = 1'b0; im_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_irwr", 32'(irwr), 32'd0);
    check("rst_ir_data", ir_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", {29'd0, fault, fault_code}, 32'd0);

    // 1: reset while waiting in REQ
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    check("t1_req", 32'(im_req), 32'd1);
    check("t1_addr", im_addr, 32'h0000_3000);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t1_async_im_req", 32'(im_req), 32'd0);
    check("t1_async_pc", pc, 32'h0000_3000);
    check("t1_async_irwr", 32'(irwr), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // 2: single fetch with one-cycle IM
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    check("t2_req", 32'(im_req), 32'd1);
    check("t2_irwr_early", 32'(irwr), 32'd0);
    im_ack = 1'b1; im_rdata = 32'h2008_0005; tick(); im_ack = 1'b0;
    check("t2_irwr", 32'(irwr), 32'd1);
    check("t2_ir_data", ir_data, 32'h2008_0005);
    check("t2_pc", pc, 32'h0000_3004);
    check("t2_req_drop", 32'(im_req), 32'd0);
    tick();
    check("t2_irwr_pulse", 32'(irwr), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);

    // 3: redirects during the wait, last one wins, applied at completion
    npc_wr = 1'b1; npc = 32'h0000_3000; tick(); npc_wr = 1'b0;
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      npc_wr = (i < 2);
      npc    = (i == 0) ? 32'h0000_3100 : 32'h0000_3200;
      tick();
      check("t3_addr_hold", im_addr, 32'h0000_3000);
      check("t3_req_hold", 32'(im_req), 32'd1);
      check("t3_no_irwr", 32'(irwr), 32'd0);
      check("t3_pc_hold", pc, 32'h0000_3000);
    end
    npc_wr = 1'b0;
    im_ack = 1'b1; im_rdata = 32'hDEAD_0001; tick(); im_ack = 1'b0;
    check("t3_pc", pc, 32'h0000_3200);
    check("t3_irwr", 32'(irwr), 32'd1);
    check("t3_ir_data", ir_data, 32'hDEAD_0001);
    check("t3_addr_final", im_addr, 32'h0000_3000);
    tick();
    check("t3_irwr_pulse", 32'(irwr), 32'd0);

    // 4: IM timeout after 16 wait cycles, then vector load
    npc_wr = 1'b1; npc = 32'h0000_3000; tick(); npc_wr = 1'b0;
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("t4_waiting", {30'd0, fault, im_req}, 32'd1);
      check("t4_no_irwr", 32'(irwr), 32'd0);
    end
    tick();
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_code", 32'(fault_code), 32'd2);
    check("t4_req_drop", 32'(im_req), 32'd0);
    check("t4_pc", pc, 32'h0000_3000);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_no_irwr_end", 32'(irwr), 32'd0);
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    check("t4_fetch_ignored", {30'd0, fault, im_req}, 32'd2);
    npc_wr = 1'b1; npc = 32'h0000_4180; tick(); npc_wr = 1'b0;
    check("t4_clear_fault", {29'd0, fault, fault_code}, 32'd0);
    check("t4_vec_pc", pc, 32'h0000_4180);
    check("t4_idle", 32'(busy), 32'd0);

    // 5: misaligned PC
    npc_wr = 1'b1; npc = 32'h0000_3002; tick(); npc_wr = 1'b0;
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_code", 32'(fault_code), 32'd1);
    check("t5_no_req", 32'(im_req), 32'd0);
    npc_wr = 1'b1; npc = 32'h0000_3000; tick(); npc_wr = 1'b0;
    check("t5_recover", {30'd0, fault, busy}, 32'd0);

    // 6: redirect beats fetch, PC wrap, spurious ack
    fetch_en = 1'b1; npc_wr = 1'b1; npc = 32'hFFFF_FFFC; tick();
    fetch_en = 1'b0; npc_wr = 1'b0;
    check("t6_prio_pc", pc, 32'hFFFF_FFFC);
    check("t6_prio_no_req", {30'd0, im_req, busy}, 32'd0);
    fetch_en = 1'b1; tick(); fetch_en = 1'b0;
    check("t6_wrap_addr", im_addr, 32'hFFFF_FFFC);
    im_ack = 1'b1; im_rdata = 32'h1234_5678; tick(); im_ack = 1'b0;
    check("t6_wrap_pc", pc, 32'h0000_0000);
    check("t6_wrap_irwr", 32'(irwr), 32'd1);
    tick();
    im_ack = 1'b1; im_rdata = 32'hBAD0_BAD0; tick(); im_ack = 1'b0;
    check("t6_spur_irwr", 32'(irwr), 32'd0);
    check("t6_spur_busy", 32'(busy), 32'd0);
    check("t6_spur_ir", ir_data, 32'h1234_5678);
    check("t6_spur_pc", pc, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction fetch sequencer. It owns the PC, drives the instruction-memory read handshake, and produces the write-enable and data for the instruction register: the writer into the IR buffer. It sits between the main controller (which requests fetches and redirects the PC) and IM, and tolerates variable IM latency with a bounded wait.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset.
MAX_WAIT, 16, IM cycles allowed for im_ack before timeout fault (2..255).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
fetch_en  in  1  controller request to fetch the instruction at the current PC.
npc_wr  in  1  load npc into PC (branch/jump redirect).
npc  in  32  redirect target.
im_req  out  1  IM read request.
im_addr  out  32  IM word address (byte address, bits[1:0]=0).
im_ack  in  1  IM data valid; one-cycle pulse.
im_rdata  in  32  IM read data, valid with im_ack.
irwr  out  1  IR write enable, one-cycle pulse.
ir_data  out  32  instruction to IR.
pc  out  32  current PC.
busy  out  1  high whenever state is not IDLE.
fault  out  1  sticky error flag.
fault_code  out  2  00 none, 01 misaligned PC, 10 IM timeout.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, im_req=0, im_addr=0, irwr=0, ir_data=0, busy=0, fault=0, fault_code=00, wait counter=0, pending redirect cleared. All outputs are registered, so im_req drops on rst assertion with no clock needed.
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - npc_wr=1: pc<=npc, any fetch_en that cycle is dropped. npc_wr has priority; the controller must reassert fetch_en.
  - fetch_en=1, npc_wr=0, pc[1:0]!=0: go to FAULT with code 01.
  - fetch_en=1, npc_wr=0, aligned PC: go to REQ, im_req<=1, im_addr<=pc, counter<=0.
- REQ:
  - im_req and im_addr are held stable until the im_ack cycle.
  - On im_ack: ir_data<=im_rdata, irwr<=1, im_req<=0, go to DONE.
  - The PC update is applied on the same edge: pc<=pending npc if a redirect is pending, else pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Without im_ack: counter+1. When counter reaches MAX_WAIT-1 without ack: im_req<=0, go to FAULT with code 10, pc unchanged.
  - npc_wr during REQ: npc is latched as a pending redirect; the last write wins. It is not applied until completion.
  - fetch_en during REQ is ignored.
- DONE: lasts one cycle; irwr=1 only here. Then IDLE, irwr<=0. npc_wr in DONE behaves as in IDLE.
- FAULT:
  - fault=1 and fault_code are held; im_req=0; busy=1.
  - Exit only via npc_wr: pc<=npc, fault cleared, go to IDLE. This is the exception-vector load.
  - fetch_en is ignored in FAULT.
- Latency: with fetch_en at edge T and im_ack sampled at edge T+k (k>=1), irwr and ir_data are valid during cycle T+k+1. Minimum fetch is 3 cycles edge-to-idle.
- Back-to-back fetches: fetch_en during DONE is ignored. A new fetch starts from IDLE, giving one bubble per fetch.
- im_ack outside REQ is ignored, with no state change.

Decomposition:
- Shared package fetch_pkg:
  - State encoding localparams: IDLE=2'd0, REQ=2'd1, DONE=2'd2, FAULT=2'd3.
  - Fault codes FC_NONE, FC_MISALIGN, FC_TIMEOUT.
  - Default RESET_PC, reused by the PC/NPC logic.
- One sub-module: fetch_wait_timer, a MAX_WAIT down-counter with clear/enable and an expire output. Everything else stays in fetch_seq.

Test Plan:
1. Reset mid-REQ: rst during REQ -> im_req=0 immediately; pc=32'h0000_3000; irwr=0; state IDLE.
2. Single fetch, 1-cycle IM: fetch_en at pc=3000, im_ack next cycle with im_rdata=32'h2008_0005 -> one irwr pulse, ir_data=20080005, pc=32'h0000_3004, busy low afterwards.
3. Redirect during wait: fetch_en, npc_wr npc=32'h0000_3100 then npc=32'h0000_3200 in REQ, ack after 5 cycles -> pc=32'h0000_3200, irwr one pulse, im_addr stayed 3000 throughout.
4. Timeout: fetch_en, no im_ack for 16 cycles -> fault=1, code=10, im_req=0, pc=3000, irwr never asserted. Then npc_wr npc=32'h0000_4180 -> fault=0, pc=4180, IDLE.
5. Misaligned: npc_wr npc=32'h0000_3002, fetch_en -> code=01 next cycle, im_req never asserted.
6. Priority and wrap:
   - Same-cycle fetch_en+npc_wr in IDLE -> PC loaded, no request issued.
   - pc=32'hFFFF_FFFC fetch completes -> pc=0.
   - Spurious im_ack in IDLE -> no irwr.
